// File: rtl/jtkiwi_vram.sv
// Video memory arbiter: 8 kB tile/object VRAM, 1 kB object-control RAM and video flags,
// time-multiplexed over the 4-pixel slot (0: CPU, 1/3: tile scan, 2: object scan).
module jtkiwi_vram #(
    parameter int VRAM_AW = 13,
    parameter int OBJ_AW  = 10
)(
    input  logic               rst,
    input  logic               clk,
    input  logic               pxl_cen,
    input  logic [8:0]         hcnt,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_dout,
    input  logic               cpu_rnw,
    input  logic               vram_cs,
    input  logic               vctrl_cs,
    input  logic               vflag_cs,
    output logic [7:0]         vram_dout,
    input  logic [VRAM_AW-1:0] tile_addr,
    output logic [7:0]         tile_dout,
    output logic               tile_ok,
    input  logic [OBJ_AW-1:0]  obj_addr,
    output logic [7:0]         obj_dout,
    output logic               obj_ok,
    output logic               flip,
    output logic               obj_bank,
    output logic [7:0]         vflags
);

    logic [1:0] slot;
    logic       last, cpu_slot, tile_slot, obj_slot;
    logic       sel_obj, sel_vram, cpu_cs;
    logic       wr_req, wr_last, wr_pend, wr_commit;
    logic       flag_req, flag_last;
    logic       unused_hcnt;

    logic [VRAM_AW-1:0] vram_a, vram_a_l;
    logic [OBJ_AW-1:0]  obj_a, obj_a_l;
    logic               vram_we, obj_we;
    logic [7:0]         vram_q, obj_q;
    logic [7:0]         vram_mem [0:(1<<VRAM_AW)-1];
    logic [7:0]         obj_mem  [0:(1<<OBJ_AW)-1];

    assign unused_hcnt = ^hcnt[8:2];

    // Last clk of a slot: the enable that is about to move slot to a new value
    assign last      = pxl_cen && (hcnt[1:0] != slot);
    assign cpu_slot  = (slot == 2'd0);
    assign tile_slot = slot[0];
    assign obj_slot  = (slot == 2'd2);

    // Object-control select has priority should both selects ever overlap
    assign sel_obj  = vctrl_cs;
    assign sel_vram = vram_cs & ~vctrl_cs;
    assign cpu_cs   = vram_cs | vctrl_cs;

    // A strobe that rises outside slot 0 stays pending until the CPU slot comes round
    assign wr_req    = cpu_cs & ~cpu_rnw;
    assign wr_commit = cpu_slot & wr_req & (wr_pend | ~wr_last);
    assign vram_we   = wr_commit & sel_vram;
    assign obj_we    = wr_commit & sel_obj;
    assign flag_req  = vflag_cs & ~cpu_rnw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= 2'd0;
            wr_last   <= 1'b1;
            wr_pend   <= 1'b0;
            flag_last <= 1'b1;
        end else begin
            if (pxl_cen) slot <= hcnt[1:0];
            wr_last   <= wr_req;
            flag_last <= flag_req;
            if (wr_commit || !wr_req)
                wr_pend <= 1'b0;
            else if (!wr_last)
                wr_pend <= 1'b1;
        end
    end

    // Port address muxes: the slot owner drives, otherwise the last address is held
    always_comb begin
        vram_a = vram_a_l;
        if (cpu_slot && sel_vram)
            vram_a = cpu_addr;
        else if (tile_slot)
            vram_a = tile_addr;
    end

    always_comb begin
        obj_a = obj_a_l;
        if (cpu_slot && sel_obj)
            obj_a = cpu_addr[OBJ_AW-1:0];
        else if (obj_slot)
            obj_a = obj_addr;
    end

    always_ff @(posedge clk) begin
        vram_a_l <= vram_a;
        obj_a_l  <= obj_a;
        if (vram_we) vram_mem[vram_a] <= cpu_dout;
        vram_q <= vram_mem[vram_a];
        if (obj_we) obj_mem[obj_a] <= cpu_dout;
        obj_q <= obj_mem[obj_a];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_dout <= 8'd0;
            tile_dout <= 8'd0;
            tile_ok   <= 1'b0;
            obj_dout  <= 8'd0;
            obj_ok    <= 1'b0;
            flip      <= 1'b0;
            obj_bank  <= 1'b0;
            vflags    <= 8'd0;
        end else begin
            tile_ok <= 1'b0;
            obj_ok  <= 1'b0;
            if (cpu_slot && cpu_cs)
                vram_dout <= sel_obj ? obj_q : vram_q;
            if (last && tile_slot) begin
                tile_dout <= vram_q;
                tile_ok   <= 1'b1;
            end
            if (last && obj_slot) begin
                obj_dout <= obj_q;
                obj_ok   <= 1'b1;
            end
            if (flag_req && !flag_last) begin
                if (cpu_addr[0])
                    vflags <= cpu_dout;
                else begin
                    flip     <= cpu_dout[6];
                    obj_bank <= cpu_dout[7];
                end
            end
        end
    end

endmodule

// File: tb/tb_jtkiwi_vram.sv
// Bench for jtkiwi_vram: directed scenarios plus random traffic against array models.
module tb_jtkiwi_vram;

    logic        rst, clk, pxl_cen, cen_en;
    logic [8:0]  hcnt;
    logic [1:0]  div, slot_m;
    logic [12:0] cpu_addr, tile_addr;
    logic [9:0]  obj_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw, vram_cs, vctrl_cs, vflag_cs;
    logic [7:0]  vram_dout, tile_dout, obj_dout, vflags;
    logic        tile_ok, obj_ok, flip, obj_bank;

    logic [7:0]  vram_m [0:8191];
    logic [7:0]  obj_m  [0:1023];
    logic        flip_m, bank_m;
    logic [7:0]  vflags_m;
    int          total, bad;

    jtkiwi_vram #(.VRAM_AW(13), .OBJ_AW(10)) dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hcnt(hcnt),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .vram_cs(vram_cs), .vctrl_cs(vctrl_cs), .vflag_cs(vflag_cs),
        .vram_dout(vram_dout),
        .tile_addr(tile_addr), .tile_dout(tile_dout), .tile_ok(tile_ok),
        .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_ok(obj_ok),
        .flip(flip), .obj_bank(obj_bank), .vflags(vflags)
    );

    always #5 clk = ~clk;

    // Pixel enable every 4th clk; hcnt advances on it and the slot follows the old hcnt
    assign pxl_cen = (div == 2'd3) && cen_en;
    always @(posedge clk) begin
        div <= div + 2'd1;
        if (pxl_cen) hcnt <= hcnt + 9'd1;
        if (rst) slot_m <= 2'd0;
        else if (pxl_cen) slot_m <= hcnt[1:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto_slot(input logic [1:0] s);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(slot_m == s && div == 2'd0) && n < 64);
        if (n >= 64) chk("slot_wait", 32'(n), 32'd0);
    endtask

    task automatic cpu_write(input logic vs, input logic os, input logic [12:0] a, input logic [7:0] d);
        goto_slot(2'd0);
        cpu_addr = a; cpu_dout = d; vram_cs = vs; vctrl_cs = os; cpu_rnw = 1'b0;
        @(negedge clk);
        vram_cs = 1'b0; vctrl_cs = 1'b0; cpu_rnw = 1'b1;
        @(negedge clk);
        if (os) obj_m[a[9:0]] = d;
        else if (vs) vram_m[a] = d;
    endtask

    task automatic cpu_read(input logic os, input logic [12:0] a, input logic [7:0] exp, input string tag);
        goto_slot(2'd0);
        cpu_addr = a; cpu_rnw = 1'b1; vram_cs = ~os; vctrl_cs = os;
        @(negedge clk);
        @(negedge clk);
        chk(tag, 32'(vram_dout), 32'(exp));
        vram_cs = 1'b0; vctrl_cs = 1'b0;
    endtask

    task automatic wait_tile(input logic [7:0] exp, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!tile_ok && n < 64);
        chk({tag, "_seen"}, 32'(n < 64), 32'd1);
        chk(tag, 32'(tile_dout), 32'(exp));
        @(negedge clk);
        chk({tag, "_1clk"}, 32'(tile_ok), 32'd0);
    endtask

    task automatic wait_obj(input logic [7:0] exp, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!obj_ok && n < 64);
        chk({tag, "_seen"}, 32'(n < 64), 32'd1);
        chk(tag, 32'(obj_dout), 32'(exp));
        @(negedge clk);
        chk({tag, "_1clk"}, 32'(obj_ok), 32'd0);
    endtask

    task automatic scan_tile(input logic [12:0] a, input logic [7:0] exp, input string tag);
        tile_addr = a;
        goto_slot(2'd0);
        wait_tile(exp, tag);
    endtask

    task automatic scan_obj(input logic [9:0] a, input logic [7:0] exp, input string tag);
        obj_addr = a;
        goto_slot(2'd1);
        wait_obj(exp, tag);
    endtask

    task automatic flag_write(input logic a0, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = {12'd0, a0}; cpu_dout = d; vflag_cs = 1'b1; cpu_rnw = 1'b0;
        @(negedge clk);
        vflag_cs = 1'b0; cpu_rnw = 1'b1;
        @(negedge clk);
        if (a0) vflags_m = d;
        else begin flip_m = d[6]; bank_m = d[7]; end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_flip"}, 32'(flip), 32'(flip_m));
        chk({tag, "_bank"}, 32'(obj_bank), 32'(bank_m));
        chk({tag, "_vflags"}, 32'(vflags), 32'(vflags_m));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {vram_dout, tile_dout, obj_dout, vflags},    32'd0);
        chk({tag, "_bits"}, {28'd0, flip, obj_bank, tile_ok, obj_ok}, 32'd0);
    endtask

    initial begin
        logic [12:0] raddr [$];
        logic [9:0]  oaddr [$];
        logic [12:0] a;
        logic [9:0]  oa;
        int          pulses;

        total = 0; bad = 0;
        clk = 1'b0; rst = 1'b1; cen_en = 1'b1; div = 2'd0; hcnt = 9'd0; slot_m = 2'd0;
        cpu_addr = 13'd0; cpu_dout = 8'd0; cpu_rnw = 1'b1;
        vram_cs = 1'b0; vctrl_cs = 1'b0; vflag_cs = 1'b0;
        tile_addr = 13'd0; obj_addr = 10'd0;
        flip_m = 1'b0; bank_m = 1'b0; vflags_m = 8'd0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Write then read back through the CPU and the tile scan
        cpu_write(1'b1, 1'b0, 13'h0123, 8'hA5);
        cpu_read(1'b0, 13'h0123, 8'hA5, "cpu_rd_a5");
        scan_tile(13'h0123, 8'hA5, "tile_a5");

        // Long strobe with data changing mid-way must write only once
        goto_slot(2'd0);
        cpu_addr = 13'h0345; cpu_dout = 8'h11; vram_cs = 1'b1; cpu_rnw = 1'b0;
        repeat (4) @(negedge clk);
        cpu_dout = 8'h22;
        repeat (4) @(negedge clk);
        vram_cs = 1'b0; cpu_rnw = 1'b1;
        vram_m[13'h0345] = 8'h11;
        cpu_read(1'b0, 13'h0345, vram_m[13'h0345], "single_pulse");

        // Object RAM write must not alias into VRAM
        cpu_write(1'b1, 1'b0, 13'h03FF, 8'h77);
        cpu_write(1'b0, 1'b1, 13'h03FF, 8'h3C);
        scan_obj(10'h3FF, 8'h3C, "obj_3c");
        cpu_read(1'b0, 13'h03FF, 8'h77, "vram_unaliased");
        cpu_read(1'b1, 13'h03FF, 8'h3C, "cpu_rd_obj");

        // Both selects high: object-control RAM takes the write
        cpu_write(1'b1, 1'b0, 13'h0055, 8'h12);
        cpu_write(1'b1, 1'b1, 13'h0055, 8'h66);
        scan_obj(10'h055, 8'h66, "both_cs_obj");
        cpu_read(1'b0, 13'h0055, 8'h12, "both_cs_vram");

        // Write raised in slot 3 is deferred to slot 0
        cpu_write(1'b1, 1'b0, 13'h0200, 8'h10);
        tile_addr = 13'h0200;
        goto_slot(2'd3);
        cpu_addr = 13'h0200; cpu_dout = 8'h99; vram_cs = 1'b1; cpu_rnw = 1'b0;
        wait_tile(8'h10, "defer_old");
        wait_tile(8'h99, "defer_new");
        vram_cs = 1'b0; cpu_rnw = 1'b1;
        vram_m[13'h0200] = 8'h99;

        // Flag registers
        flag_write(1'b0, 8'hC0);
        chk_flags("flag_c0");
        flag_write(1'b1, 8'h5A);
        chk_flags("flag_5a");

        // pxl_cen stuck low: no scan strobes
        @(negedge clk);
        cen_en = 1'b0;
        pulses = 0;
        repeat (24) begin
            @(negedge clk);
            if (tile_ok || obj_ok) pulses++;
        end
        chk("cen_stuck", 32'(pulses), 32'd0);
        cen_en = 1'b1;
        scan_tile(13'h0123, 8'hA5, "cen_resume");

        // Reset in the middle of a pending write, strobe still high after release
        cpu_write(1'b1, 1'b0, 13'h0456, 8'h42);
        cpu_read(1'b0, 13'h0456, 8'h42, "pre_rst_rd");
        goto_slot(2'd3);
        cpu_addr = 13'h0456; cpu_dout = 8'hEE; vram_cs = 1'b1; cpu_rnw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_release");
        flip_m = 1'b0; bank_m = 1'b0; vflags_m = 8'd0;
        repeat (8) @(negedge clk);
        vram_cs = 1'b0; cpu_rnw = 1'b1;
        cpu_read(1'b0, 13'h0456, 8'h42, "rst_no_write");
        chk_flags("rst_flags");

        // Random traffic against the array models
        for (int i = 0; i < 12; i++) begin
            a = 13'($urandom_range(0, 8191));
            raddr.push_back(a);
            cpu_write(1'b1, 1'b0, a, 8'($urandom));
        end
        for (int i = 0; i < 12; i++)
            cpu_read(1'b0, raddr[i], vram_m[raddr[i]], "rnd_cpu_rd");
        for (int i = 0; i < 4; i++)
            scan_tile(raddr[i], vram_m[raddr[i]], "rnd_tile");
        for (int i = 0; i < 6; i++) begin
            oa = 10'($urandom_range(0, 1023));
            oaddr.push_back(oa);
            cpu_write(1'b0, 1'b1, {3'd0, oa}, 8'($urandom));
        end
        for (int i = 0; i < 6; i++)
            scan_obj(oaddr[i], obj_m[oaddr[i]], "rnd_obj");
        for (int i = 0; i < 6; i++) begin
            flag_write(1'($urandom), 8'($urandom));
            chk_flags("rnd_flag");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
